dmem_byte_arbiter: RTL and testbench



---
 rtl/dmem_byte_arbiter_pkg.sv | 22 ++
 rtl/dmem_byte_arbiter_if.sv | 49 ++++
 rtl/dmem_byte_arbiter_rr_arb2.sv | 25 ++
 rtl/dmem_byte_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_byte_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_byte_arbiter_pkg.sv
// Shared types and constants for the byte-serial data-memory arbiter.
// Holds the FSM state encoding, requester IDs and the byte-lane helper.
package dmem_arb_pkg;

    localparam int NBYTES = 4;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Big-endian lane mapping: byte index 0 is the word's MSB.
    function automatic logic [4:0] lane_lsb(input logic [1:0] idx);
        return 5'(8 * (NBYTES - 1 - int'(idx)));
    endfunction

endpackage

// File: rtl/dmem_byte_arbiter_if.sv
// Bundles both word requesters, the byte memory port and the status outputs.
// slave is the arbiter's view; master is the requesters/memory side.
interface dmem_byte_arbiter_if #(
    parameter int AW = 5
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata;
    logic          c_ack;
    logic [31:0]   c_rdata;

    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [31:0]   l_wdata;
    logic          l_ack;
    logic [31:0]   l_rdata;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wdata;
    logic [7:0]    m_rdata;

    logic          busy;
    logic [1:0]    grant;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_ack, l_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata,
        output busy, grant
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_ack, l_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata,
        input  busy, grant
    );

endinterface

// File: rtl/dmem_byte_arbiter_rr_arb2.sv
// Two-way round-robin pick; purely combinational, the last-grant
// register lives in the parent so the pick only moves on completion.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (last_grant == REQ_LOAD) gnt[REQ_CORE] = 1'b1;
                else                        gnt[REQ_LOAD] = 1'b1;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_byte_arbiter.sv
// Shares a byte-wide memory between core and loader word requesters,
// sequencing each 32-bit access as four big-endian byte cycles.
module dmem_byte_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_byte_arbiter_if.slave bus
);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    cnt;
    logic          owner;
    logic          last_grant;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rbuf;
    logic [31:0]   c_rdata_q;
    logic [31:0]   l_rdata_q;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          start;
    logic          busy;

    assign req[REQ_CORE] = bus.c_req;
    assign req[REQ_LOAD] = bus.l_req;

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign start = (state == IDLE) && (gnt != 2'b00);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = XFER;
            XFER: if (cnt == 2'd3) state_nxt = we_q ? DONE : TAIL;
            TAIL: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the read-word registers are plain flops, so they are cleared on reset; the byte memory itself is external and keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            owner      <= REQ_CORE;
            last_grant <= REQ_LOAD;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf       <= '0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            if (start) begin
                owner   <= gnt[REQ_LOAD];
                we_q    <= gnt[REQ_LOAD] ? bus.l_we    : bus.c_we;
                addr_q  <= gnt[REQ_LOAD] ? bus.l_addr  : bus.c_addr;
                wdata_q <= gnt[REQ_LOAD] ? bus.l_wdata : bus.c_wdata;
                cnt     <= '0;
            end

            if (state == XFER) begin
                cnt <= cnt + 2'd1;
                // Memory returns the byte one cycle after issue, so lane cnt-1 lands now.
                if (!we_q && cnt != 2'd0)
                    rbuf[lane_lsb(cnt - 2'd1) +: 8] <= bus.m_rdata;
            end

            if (state == TAIL) begin
                if (owner == REQ_LOAD) l_rdata_q <= {rbuf[31:8], bus.m_rdata};
                else                   c_rdata_q <= {rbuf[31:8], bus.m_rdata};
            end

            if (state == DONE)
                last_grant <= owner;
        end
    end

    assign busy = (state != IDLE);

    // Memory port is a function of registered state only.
    assign bus.m_en    = (state == XFER);
    assign bus.m_we    = (state == XFER) && we_q;
    assign bus.m_addr  = addr_q + AW'(cnt);
    assign bus.m_wdata = wdata_q[lane_lsb(cnt) +: 8];

    assign bus.busy    = busy;
    assign bus.grant   = busy ? ((owner == REQ_LOAD) ? 2'b10 : 2'b01) : 2'b00;
    assign bus.c_ack   = (state == DONE) && (owner == REQ_CORE);
    assign bus.l_ack   = (state == DONE) && (owner == REQ_LOAD);
    assign bus.c_rdata = c_rdata_q;
    assign bus.l_rdata = l_rdata_q;

endmodule

// File: tb/tb_dmem_byte_arbiter.sv
// Scoreboard bench for dmem_byte_arbiter: stimulus pushes expected byte
// writes and acks; a negedge monitor pops and compares them.
module tb_dmem_byte_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_byte_arbiter_if #(.AW(5)) bus ();

    dmem_byte_arbiter #(.AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Byte memory model: one-cycle read latency, preloaded on the first edge.
    logic [7:0] mem [32];
    logic [7:0] rd = 8'h00;
    bit         mem_ready = 1'b0;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            8:       return 8'h11;
            9:       return 8'h22;
            10:      return 8'h33;
            11:      return 8'h44;
            default: return 8'(8'h80 + i);
        endcase
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_byte(i);
            mem_ready <= 1'b1;
        end else if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
            else          rd <= mem[bus.m_addr];
        end
    end
    assign bus.m_rdata = rd;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    typedef struct {
        logic        who;
        logic [31:0] c_rd;
        logic [31:0] l_rd;
        int          cyc;
    } ack_t;

    wr_t         wrq [$];
    ack_t        ackq [$];
    wr_t         mon_w;
    ack_t        mon_a;
    logic [31:0] exp_c_rdata = '0;
    logic [31:0] exp_l_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_bytes(input logic [4:0] base, input logic [31:0] word,
                              input int first, input int nb);
        wr_t e;
        for (int k = 0; k < nb; k++) begin
            e.addr = base + 5'(k);
            e.data = 8'(word >> (8 * (3 - k)));
            e.cyc  = first + k;
            wrq.push_back(e);
        end
    endtask

    task automatic push_ack(input logic who, input int at);
        ack_t a;
        a.who  = who;
        a.c_rd = exp_c_rdata;
        a.l_rd = exp_l_rdata;
        a.cyc  = at;
        ackq.push_back(a);
    endtask

    task automatic drive(input logic who, input logic we, input logic [4:0] a, input logic [31:0] d);
        if (who) begin
            bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = a; bus.l_wdata = d;
        end else begin
            bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
        end
    endtask

    task automatic drop(input logic who);
        if (who) bus.l_req = 1'b0;
        else     bus.c_req = 1'b0;
    endtask

    task automatic wait_ack(input logic who);
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (who ? bus.l_ack : bus.c_ack) return;
        end
        fail_now(who ? "ack_timeout_loader" : "ack_timeout_core");
    endtask

    task automatic run_access(input logic who, input logic we, input logic [4:0] a,
                              input logic [31:0] d, input logic [31:0] exp_rd, input bit glitch);
        int s;
        @(posedge clk); #1;
        s = cyc;
        if (we) begin
            push_bytes(a, d, s + 1, 4);
            push_ack(who, s + 5);
        end else begin
            if (who) exp_l_rdata = exp_rd;
            else     exp_c_rdata = exp_rd;
            push_ack(who, s + 6);
        end
        drive(who, we, a, d);
        if (glitch) begin
            repeat (2) @(posedge clk);
            #1;
            bus.c_addr  = 5'd20;
            bus.c_wdata = 32'h12345678;
        end
        wait_ack(who);
        drop(who);
    endtask

    // Monitor: every memory write and every ack must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_en && bus.m_we) begin
                if (wrq.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    mon_w = wrq.pop_front();
                    check("wr_addr", 32'(bus.m_addr), 32'(mon_w.addr));
                    check("wr_data", 32'(bus.m_wdata), 32'(mon_w.data));
                    check("wr_cycle", cyc, mon_w.cyc);
                end
            end
            if (bus.c_ack || bus.l_ack) begin
                if (bus.c_ack && bus.l_ack) begin
                    fail_now("double_ack");
                end else if (ackq.size() == 0) begin
                    fail_now("unexpected_ack");
                end else begin
                    mon_a = ackq.pop_front();
                    check("ack_who", 32'(bus.l_ack), 32'(mon_a.who));
                    check("ack_cycle", cyc, mon_a.cyc);
                    check("ack_grant", 32'(bus.grant), mon_a.who ? 32'd2 : 32'd1);
                    check("ack_busy", 32'(bus.busy), 32'd1);
                    check("c_rdata", bus.c_rdata, mon_a.c_rd);
                    check("l_rdata", bus.l_rdata, mon_a.l_rd);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_en",  32'(bus.m_en), 32'd0);
        check("rst_m_we",  32'(bus.m_we), 32'd0);
        check("rst_acks",  32'({bus.c_ack, bus.l_ack}), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_m_bus", 32'({bus.m_addr, bus.m_wdata}), 32'd0);
        check("rst_c_rdata", bus.c_rdata, 32'd0);
        check("rst_l_rdata", bus.l_rdata, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Core write at 4.
        run_access(1'b0, 1'b1, 5'd4, 32'hDEADBEEF, 32'h0, 1'b0);
        check("t1_mem4", 32'(mem[4]), 32'hDE);
        check("t1_mem7", 32'(mem[7]), 32'hEF);

        // Loader read of preloaded 11 22 33 44 at 8.
        run_access(1'b1, 1'b0, 5'd8, 32'h0, 32'h11223344, 1'b0);

        // Tie after core-first history: core, then loader, then core again.
        @(posedge clk); #1;
        s = cyc;
        push_bytes(5'd16, 32'h01020304, s + 1, 4);
        push_ack(1'b0, s + 5);
        push_bytes(5'd20, 32'hA0B0C0D0, s + 7, 4);
        push_ack(1'b1, s + 11);
        push_bytes(5'd16, 32'h01020304, s + 13, 4);
        push_ack(1'b0, s + 17);
        drive(1'b0, 1'b1, 5'd16, 32'h01020304);
        drive(1'b1, 1'b1, 5'd20, 32'hA0B0C0D0);
        wait_ack(1'b0);
        wait_ack(1'b1);
        wait_ack(1'b0);
        drop(1'b0);
        drop(1'b1);

        // Address wrap from 30.
        run_access(1'b0, 1'b1, 5'd30, 32'hA1B2C3D4, 32'h0, 1'b0);
        check("t4_mem30", 32'(mem[30]), 32'hA1);
        check("t4_mem0",  32'(mem[0]),  32'hC3);
        check("t4_mem1",  32'(mem[1]),  32'hD4);

        // Reset during XFER cnt=2 of a core write at 12.
        @(posedge clk); #1;
        s = cyc;
        push_bytes(5'd12, 32'h55667788, s + 1, 2);
        drive(1'b0, 1'b1, 5'd12, 32'h55667788);
        repeat (3) @(posedge clk);
        #1;
        check("t5_pre_m_addr", 32'(bus.m_addr), 32'd14);
        rst_n = 1'b0;
        #1;
        check("t5_m_en",  32'(bus.m_en), 32'd0);
        check("t5_m_we",  32'(bus.m_we), 32'd0);
        check("t5_busy",  32'(bus.busy), 32'd0);
        check("t5_grant", 32'(bus.grant), 32'd0);
        check("t5_c_ack", 32'(bus.c_ack), 32'd0);
        check("t5_l_rdata", bus.l_rdata, 32'd0);
        exp_l_rdata = '0;
        drop(1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_mem12", 32'(mem[12]), 32'h55);
        check("t5_mem13", 32'(mem[13]), 32'h66);
        check("t5_mem14", 32'(mem[14]), 32'h8E);
        check("t5_mem15", 32'(mem[15]), 32'h8F);
        run_access(1'b1, 1'b0, 5'd8, 32'h0, 32'h11223344, 1'b0);

        // Request inputs changed after grant must not affect the transfer.
        run_access(1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 32'h0, 1'b1);
        check("t6_mem3",  32'(mem[3]),  32'hCA);
        check("t6_mem6",  32'(mem[6]),  32'h0D);
        check("t6_mem20", 32'(mem[20]), 32'hA0);

        repeat (4) @(posedge clk);
        #1;
        check("wr_queue_empty",  32'(wrq.size()),  32'd0);
        check("ack_queue_empty", 32'(ackq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
